// File: rtl/ice_bus_pkg.sv
// Shared definitions for the ICE bus controller slave path: arbiter states, policy codes, index width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ice_bus_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    // Arbitration policy codes for RR_MODE
    localparam int RR_MODE_FIXED = 0;
    localparam int RR_MODE_RR    = 1;

    // Width of a requester index; a single requester still needs one bit
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ice_slave_arbiter_if.sv
// Request/grant bundle between the ICE slaves and the slave arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests are levels held until the granted slave pulses its tail.
interface ice_slave_arbiter_if #(
    parameter int NUM_DEV = 7
);
    import ice_bus_pkg::*;

    localparam int IDX_W = idx_w(NUM_DEV);

    logic [NUM_DEV-1:0] sl_arb_request;
    logic               sl_latch_tail;
    logic [NUM_DEV-1:0] sl_arb_grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               arb_timeout;
    logic [IDX_W-1:0]   timeout_idx;

    // Arbiter side
    modport master (
        input  sl_arb_request, sl_latch_tail,
        output sl_arb_grant, grant_idx, grant_valid, arb_timeout, timeout_idx
    );

    // Requesting slave side
    modport slave (
        output sl_arb_request, sl_latch_tail,
        input  sl_arb_grant, grant_idx, grant_valid, arb_timeout, timeout_idx
    );

endinterface

// File: rtl/ice_rr_picker.sv
// Combinational winner picker: lowest set request at or above a start pointer, wrapping modulo NUM_DEV.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the winner is taken.
module ice_rr_picker
    import ice_bus_pkg::*;
#(
    parameter int NUM_DEV = 7,
    parameter int IDX_W   = idx_w(NUM_DEV)
) (
    input  logic [NUM_DEV-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               rr_mode_i,
    output logic [NUM_DEV-1:0] win_oh_o,
    output logic [IDX_W-1:0]   win_idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0]     start;
    logic [2*NUM_DEV-1:0] dbl_req;
    logic                 found;

    // Lower copy is masked below the start point, upper copy supplies the wrap-around
    always_comb begin
        start     = rr_mode_i ? ptr_i : '0;
        dbl_req   = {req_i, req_i};
        found     = 1'b0;
        win_oh_o  = '0;
        win_idx_o = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (i < int'(start)) begin
                dbl_req[i] = 1'b0;
            end
        end
        for (int i = 0; i < 2 * NUM_DEV; i++) begin
            if (!found && dbl_req[i]) begin
                found                 = 1'b1;
                win_idx_o             = IDX_W'(i % NUM_DEV);
                win_oh_o[i % NUM_DEV] = 1'b1;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/ice_slave_arbiter.sv
// Grants the ICE slave TX bus to one of NUM_DEV requesters, fixed priority or round-robin (RR_MODE).
// Latency: grant 1 cycle after request from IDLE; one RELEASE cycle after every grant; outputs registered.
// Backpressure: no preemption, grant held until tail or request drop; watchdog under ICE_ARB_WATCHDOG_EN.
module ice_slave_arbiter
    import ice_bus_pkg::*;
#(
    parameter int NUM_DEV   = 7,
    parameter int RR_MODE   = RR_MODE_FIXED,
    parameter int TIMEOUT_W = 16
) (
    input  logic clk,
    input  logic reset,
    ice_slave_arbiter_if.master bus
);

    localparam int IDX_W = idx_w(NUM_DEV);

    if (NUM_DEV < 1 || NUM_DEV > 32 || TIMEOUT_W < 1 ||
        (RR_MODE != RR_MODE_FIXED && RR_MODE != RR_MODE_RR)) begin : g_bad_cfg
        $error("ice_slave_arbiter: unsupported parameter set");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_DEV-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [NUM_DEV-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               rel_tail;
    logic               rel_drop;
    logic               wd_expire;
    logic [IDX_W-1:0]   ptr_next;

    ice_rr_picker #(
        .NUM_DEV (NUM_DEV),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i     (bus.sl_arb_request),
        .ptr_i     (ptr_q),
        .rr_mode_i (RR_MODE == RR_MODE_RR),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .any_o     (win_any)
    );

    // Release causes only count while a grant is held; tail outside GRANT is ignored
    assign rel_tail = (state_q == ST_GRANT) && bus.sl_latch_tail;
    assign rel_drop = (state_q == ST_GRANT) && ((bus.sl_arb_request & grant_q) == '0);
    assign ptr_next = (idx_q == IDX_W'(NUM_DEV - 1)) ? '0 : idx_q + IDX_W'(1);

    // Next-state and next-grant: grant only from IDLE, drop on any release cause
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_GRANT;
                    grant_d = win_oh;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (rel_tail || rel_drop || wd_expire) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = ptr_next;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM and grant registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ICE_ARB_WATCHDOG_EN
    // Expire when the count of completed GRANT cycles would reach all-ones
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = ~TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 to_q, to_d;
    logic [IDX_W-1:0]     to_idx_q, to_idx_d;

    assign wd_expire = (state_q == ST_GRANT) && (cnt_q == CNT_LAST);

    // Watchdog count and timeout report; a normal release in the same cycle suppresses the pulse
    always_comb begin
        cnt_d    = cnt_q;
        to_d     = 1'b0;
        to_idx_d = to_idx_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_GRANT) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
        if (wd_expire && !rel_tail && !rel_drop) begin
            to_d     = 1'b1;
            to_idx_d = idx_q;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            to_q     <= 1'b0;
            to_idx_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            to_idx_q <= to_idx_d;
        end
    end

    assign bus.arb_timeout = to_q;
    assign bus.timeout_idx = to_idx_q;
`else
    assign wd_expire       = 1'b0;
    assign bus.arb_timeout = 1'b0;
    assign bus.timeout_idx = '0;
`endif

    assign bus.sl_arb_grant = grant_q;
    assign bus.grant_idx    = idx_q;
    assign bus.grant_valid  = valid_q;

endmodule

// File: tb/tb_ice_slave_arbiter.sv
// Bench for ice_slave_arbiter: fixed-priority, round-robin and single-requester instances.
// Expected grant indices are queued as stimulus is driven and checked when each new grant appears.
// Watchdog expectations follow ICE_ARB_WATCHDOG_EN.
module tb_ice_slave_arbiter;
    import ice_bus_pkg::*;

    localparam int N = 7;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ice_slave_arbiter_if #(.NUM_DEV(N)) if_fp ();
    ice_slave_arbiter_if #(.NUM_DEV(N)) if_rr ();
    ice_slave_arbiter_if #(.NUM_DEV(1)) if_one ();

    ice_slave_arbiter #(.NUM_DEV(N), .RR_MODE(RR_MODE_FIXED), .TIMEOUT_W(4)) u_fp (
        .clk(clk), .reset(reset), .bus(if_fp.master));
    ice_slave_arbiter #(.NUM_DEV(N), .RR_MODE(RR_MODE_RR), .TIMEOUT_W(4)) u_rr (
        .clk(clk), .reset(reset), .bus(if_rr.master));
    ice_slave_arbiter #(.NUM_DEV(1), .RR_MODE(RR_MODE_RR), .TIMEOUT_W(4)) u_one (
        .clk(clk), .reset(reset), .bus(if_one.master));

    int n_chk  = 0;
    int n_pass = 0;

    int   q_fp[$];
    int   q_rr[$];
    logic pv_fp   = 1'b0;
    logic pv_rr   = 1'b0;
    int   last_rr = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every new grant must match the next queued expectation
    always @(negedge clk) begin
        int e;
        if (if_fp.grant_valid && !pv_fp) begin
            if (q_fp.size() == 0) chk("fp_unexpected_grant", 32'(if_fp.grant_idx), 32'hFFFF_FFFF);
            else begin
                e = q_fp.pop_front();
                chk("fp_grant_idx", 32'(if_fp.grant_idx), 32'(e));
                chk("fp_grant_oh", 32'(if_fp.sl_arb_grant), 32'(1) << e);
            end
        end
        if (if_rr.grant_valid && !pv_rr) begin
            if (q_rr.size() == 0) chk("rr_unexpected_grant", 32'(if_rr.grant_idx), 32'hFFFF_FFFF);
            else begin
                e = q_rr.pop_front();
                chk("rr_grant_idx", 32'(if_rr.grant_idx), 32'(e));
                chk("rr_grant_oh", 32'(if_rr.sl_arb_grant), 32'(1) << e);
                if (last_rr >= 0) chk("rr_no_repeat", 32'(int'(if_rr.grant_idx) == last_rr), 32'd0);
                last_rr = int'(if_rr.grant_idx);
            end
        end
        pv_fp = if_fp.grant_valid;
        pv_rr = if_rr.grant_valid;
    end

    initial begin
        #300000;
        $display("FAIL tb_time_limit: got no finish, want finish");
        $fatal(1, "time limit");
    end

    initial begin
        int w;
        int lost;
        int tos;
        reset = 1'b0;
        if_fp.sl_arb_request  = '0; if_fp.sl_latch_tail  = 1'b0;
        if_rr.sl_arb_request  = '0; if_rr.sl_latch_tail  = 1'b0;
        if_one.sl_arb_request = '0; if_one.sl_latch_tail = 1'b0;
        tick(2);
        chk("rst_grant", 32'(if_fp.sl_arb_grant), 32'd0);
        chk("rst_idx", 32'(if_fp.grant_idx), 32'd0);
        chk("rst_valid", 32'(if_fp.grant_valid), 32'd0);
        chk("rst_timeout", 32'(if_fp.arb_timeout), 32'd0);
        chk("rst_timeout_idx", 32'(if_fp.timeout_idx), 32'd0);
        reset = 1'b1;
        tick();

        // Round-robin, all requesting, tail on the 3rd grant cycle
        for (int i = 0; i < 8; i++) q_rr.push_back(i % N);
        if_rr.sl_arb_request = '1;
        for (int f = 0; f < 8; f++) begin
            w = 0;
            while (!if_rr.grant_valid && w < 10) begin tick(); w++; end
            if (!if_rr.grant_valid) chk("rr_grant_wait", 32'd0, 32'd1);
            tick(2);
            if_rr.sl_latch_tail = 1'b1;
            tick();
            if_rr.sl_latch_tail = 1'b0;
            chk("rr_release", 32'(if_rr.grant_valid), 32'd0);
            if (f == 7) if_rr.sl_arb_request = '0;
        end
        tick(3);

        // Fixed priority: two simultaneous requests, then the release gap
        q_fp.push_back(2); q_fp.push_back(4);
        if_fp.sl_arb_request = 7'b0010100;
        tick();
        chk("fp_first_grant", 32'(if_fp.sl_arb_grant), 32'b0000100);
        if_fp.sl_latch_tail = 1'b1;
        tick();
        if_fp.sl_latch_tail = 1'b0;
        if_fp.sl_arb_request = 7'b0010000;
        chk("fp_release_gap", 32'(if_fp.grant_valid), 32'd0);
        tick();
        chk("fp_idle_gap", 32'(if_fp.grant_valid), 32'd0);
        tick();
        chk("fp_second_grant", 32'(if_fp.sl_arb_grant), 32'b0010000);
        if_fp.sl_latch_tail = 1'b1;
        tick();
        if_fp.sl_latch_tail = 1'b0;
        if_fp.sl_arb_request = '0;
        tick(2);

        // Abandon: slave 3 drops mid-grant with slave 1 pending
        q_fp.push_back(3);
        if_fp.sl_arb_request = 7'b0001000;
        tick();
        if_fp.sl_arb_request = 7'b0001010;
        q_fp.push_back(1);
        tick(2);
        chk("fp_no_preempt", 32'(if_fp.sl_arb_grant), 32'b0001000);
        if_fp.sl_arb_request = 7'b0000010;
        tick();
        chk("fp_abandon_release", 32'(if_fp.grant_valid), 32'd0);
        tick();
        chk("fp_abandon_idle", 32'(if_fp.grant_valid), 32'd0);
        tick();
        chk("fp_after_abandon", 32'(if_fp.sl_arb_grant), 32'b0000010);
        if_fp.sl_latch_tail = 1'b1;
        tick();
        if_fp.sl_latch_tail = 1'b0;
        if_fp.sl_arb_request = '0;
        tick(2);

        // Tail in IDLE is ignored, alone or alongside a new request
        if_fp.sl_latch_tail = 1'b1;
        tick();
        if_fp.sl_latch_tail = 1'b0;
        chk("fp_tail_idle", 32'(if_fp.grant_valid), 32'd0);
        tick();
        q_fp.push_back(2);
        if_fp.sl_arb_request = 7'b0000100;
        if_fp.sl_latch_tail = 1'b1;
        tick();
        if_fp.sl_latch_tail = 1'b0;
        tick();
        chk("fp_tail_idle_kept", 32'(if_fp.sl_arb_grant), 32'b0000100);
        if_fp.sl_latch_tail = 1'b1;
        tick();
        if_fp.sl_latch_tail = 1'b0;
        if_fp.sl_arb_request = '0;
        tick(2);

`ifdef ICE_ARB_WATCHDOG_EN
        // Watchdog: slave 5 never tails, revoked after 15 grant cycles
        q_fp.push_back(5);
        if_fp.sl_arb_request = 7'b0100000;
        tick();
        tick(14);
        chk("wd_hold_15", 32'(if_fp.grant_valid), 32'd1);
        chk("wd_no_early_pulse", 32'(if_fp.arb_timeout), 32'd0);
        tick();
        chk("wd_revoked", 32'(if_fp.grant_valid), 32'd0);
        chk("wd_pulse", 32'(if_fp.arb_timeout), 32'd1);
        chk("wd_idx", 32'(if_fp.timeout_idx), 32'd5);
        if_fp.sl_arb_request = '0;
        tick();
        chk("wd_pulse_one_cycle", 32'(if_fp.arb_timeout), 32'd0);
        chk("wd_idx_holds", 32'(if_fp.timeout_idx), 32'd5);
        tick();

        // Tail lands on the expiry cycle: normal release, no pulse
        q_fp.push_back(5);
        if_fp.sl_arb_request = 7'b0100000;
        tick();
        tick(14);
        if_fp.sl_latch_tail = 1'b1;
        tick();
        if_fp.sl_latch_tail = 1'b0;
        if_fp.sl_arb_request = '0;
        chk("wd_tail_release", 32'(if_fp.grant_valid), 32'd0);
        chk("wd_tail_wins", 32'(if_fp.arb_timeout), 32'd0);
        tick(2);
`else
        // No watchdog: a 1000-cycle hold keeps the grant
        q_fp.push_back(5);
        if_fp.sl_arb_request = 7'b0100000;
        tick();
        lost = 0;
        tos  = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (!if_fp.grant_valid) lost++;
            if (if_fp.arb_timeout) tos++;
        end
        chk("nowd_grant_kept", 32'(lost), 32'd0);
        chk("nowd_no_timeout", 32'(tos), 32'd0);
        if_fp.sl_latch_tail = 1'b1;
        tick();
        if_fp.sl_latch_tail = 1'b0;
        if_fp.sl_arb_request = '0;
        chk("nowd_tail_release", 32'(if_fp.grant_valid), 32'd0);
        tick(2);
`endif

        // Single requester in round-robin mode
        if_one.sl_arb_request = 1'b1;
        tick();
        chk("one_grant", 32'(if_one.sl_arb_grant), 32'd1);
        chk("one_idx", 32'(if_one.grant_idx), 32'd0);
        if_one.sl_latch_tail = 1'b1;
        tick();
        if_one.sl_latch_tail = 1'b0;
        chk("one_release", 32'(if_one.grant_valid), 32'd0);
        tick(2);
        chk("one_regrant", 32'(if_one.sl_arb_grant), 32'd1);
        if_one.sl_latch_tail = 1'b1;
        tick();
        if_one.sl_latch_tail = 1'b0;
        if_one.sl_arb_request = 1'b0;
        tick(2);

        // Asynchronous reset mid-grant
        q_fp.push_back(0);
        if_fp.sl_arb_request = 7'b0000001;
        tick();
        chk("rst_pre_grant", 32'(if_fp.sl_arb_grant), 32'b0000001);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_grant", 32'(if_fp.sl_arb_grant), 32'd0);
        chk("rst_async_valid", 32'(if_fp.grant_valid), 32'd0);
        chk("rst_async_timeout_idx", 32'(if_fp.timeout_idx), 32'd0);
        if_fp.sl_arb_request = '0;
        tick();
        reset = 1'b1;
        tick();

        // Round-robin from reset: slave 4 alone, then the pointer must sit at 5
        q_rr.push_back(4);
        if_rr.sl_arb_request = 7'b0010000;
        tick();
        chk("rr_slave4", 32'(if_rr.sl_arb_grant), 32'b0010000);
        if_rr.sl_latch_tail = 1'b1;
        tick();
        if_rr.sl_latch_tail = 1'b0;
        if_rr.sl_arb_request = '0;
        tick();
        q_rr.push_back(5);
        if_rr.sl_arb_request = 7'b0100001;
        tick();
        chk("rr_ptr_at_5", 32'(if_rr.sl_arb_grant), 32'b0100000);
        if_rr.sl_latch_tail = 1'b1;
        tick();
        if_rr.sl_latch_tail = 1'b0;
        if_rr.sl_arb_request = '0;
        tick(3);

        chk("fp_queue_drained", 32'(q_fp.size()), 32'd0);
        chk("rr_queue_drained", 32'(q_rr.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
